// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
// Provides the 16-bit machine word type, the MEM-stage data-memory
// access state type, and the write lane-enable encodings that the
// MEM-stage access logic uses.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/dmem_access_unit_byte_lane_align.sv
// byte_lane_align: combinational byte-lane steering for 16-bit data memory.
// Ports:
//   addr_lsb    in   address bit 0, selects the byte lane
//   is_byte     in   1 = byte access, 0 = word access
//   wdata_in    in   store data as supplied by the pipeline
//   rdata_in    in   raw word returned by the cache
//   byte_enable out  write lane enables for a store
//   wdata_out   out  store data steered onto the lanes
//   load_out    out  load result (word as-is, byte zero-extended)
module byte_lane_align
  import lc3b_types::*;
(
  input  logic       addr_lsb,
  input  logic       is_byte,
  input  lc3b_word   wdata_in,
  input  lc3b_word   rdata_in,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata_out,
  output lc3b_word   load_out
);

  always_comb begin
    byte_enable = BE_WORD;
    wdata_out   = wdata_in;
    load_out    = rdata_in;
    if (is_byte) begin
      byte_enable = addr_lsb ? BE_HI : BE_LO;
      // Replicate the low byte so either lane carries it; the enables
      // decide which one the cache actually writes.
      wdata_out   = {wdata_in[7:0], wdata_in[7:0]};
      load_out    = addr_lsb ? {8'h00, rdata_in[15:8]} : {8'h00, rdata_in[7:0]};
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store responder for the LC-3b pipeline.
// Accepts a load/store from the EX/MEM register, runs the read/write/resp
// handshake with the data cache, stalls the pipeline until completion and
// presents aligned load data to writeback. Counts stalled cycles.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_read/req_write/req_byte  request type from the control word
//   req_addr, req_wdata          effective address and store data
//   flush                        squash the current MEM-stage instruction
//   dmem_read/dmem_write         cache strobes, held for the whole access
//   dmem_address/dmem_wdata      word-aligned address and lane-steered data
//   dmem_byte_enable             write lane enables (00 on reads)
//   dmem_resp/dmem_rdata         cache completion pulse and read data
//   stall                        freeze upstream pipeline registers
//   load_data/load_valid         aligned load result and its valid strobe
//   stall_cycles                 saturating count of stalled cycles
module dmem_access_unit
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  input  logic                  flush,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [15:0]           dmem_wdata,
  output logic [1:0]            dmem_byte_enable,
  input  logic                  dmem_resp,
  input  logic [15:0]           dmem_rdata,
  output logic                  stall,
  output logic [15:0]           load_data,
  output logic                  load_valid,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  dmem_state_t           state, next_state;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] addr_q;
  lc3b_word              wdata_q;
  logic                  byte_q;
  logic                  read_q;
  logic                  squash_q;
  lc3b_word              load_data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [1:0]            lane_be;
  lc3b_word              lane_wdata;
  lc3b_word              lane_load;

  byte_lane_align u_align (
    .addr_lsb    (addr_q[0]),
    .is_byte     (byte_q),
    .wdata_in    (wdata_q),
    .rdata_in    (dmem_rdata),
    .byte_enable (lane_be),
    .wdata_out   (lane_wdata),
    .load_out    (lane_load)
  );

  always_comb begin
    next_state       = state;
    accept           = 1'b0;
    stall            = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = BE_NONE;
    load_valid       = 1'b0;
    case (state)
      IDLE: begin
        // Stall combinationally so the request is held while we latch it.
        if ((req_read || req_write) && !flush) begin
          accept     = 1'b1;
          stall      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        stall            = 1'b1;
        dmem_read        = read_q;
        dmem_write       = !read_q;
        dmem_address     = {addr_q[ADDR_WIDTH-1:1], 1'b0};
        dmem_wdata       = lane_wdata;
        dmem_byte_enable = read_q ? BE_NONE : lane_be;
        if (dmem_resp) next_state = DONE;
      end
      DONE: begin
        load_valid = read_q && !squash_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control state: FSM, squash flag, load result register, stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      squash_q    <= 1'b0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state <= next_state;
      // A flush cannot abort an in-flight cache access, so it is remembered
      // and only the writeback of the result is suppressed.
      if (accept)
        squash_q <= 1'b0;
      else if (state == ACCESS && flush)
        squash_q <= 1'b1;
      if (state == ACCESS && dmem_resp && read_q)
        load_data_q <= lane_load;
      if (stall && cnt_q != '1)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Request latch; contents only matter while ACCESS/DONE, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      byte_q  <= req_byte;
      read_q  <= req_read;
    end
  end

  assign load_data    = load_data_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  localparam int AW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_read, req_write, req_byte, flush;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic          dmem_read, dmem_write;
  logic [AW-1:0] dmem_address;
  logic [15:0]   dmem_wdata;
  logic [1:0]    dmem_byte_enable;
  logic          dmem_resp;
  logic [15:0]   dmem_rdata;
  logic          stall;
  logic [15:0]   load_data;
  logic          load_valid;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_byte         (req_byte),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .flush            (flush),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .stall            (stall),
    .load_data        (load_data),
    .load_valid       (load_valid),
    .stall_cycles     (stall_cycles)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction and where it is in its life.
  // phase 0 = no transaction, 1 = waiting on the cache, 2 = completion cycle.
  int          m_phase = 0;
  logic        m_rd = 1'b0, m_byte = 1'b0, m_squash = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_load = '0;
  int          m_stalls = 0;
  bit          chk_en = 0;

  function automatic bit exp_stall();
    return (m_phase == 1) || (m_phase == 0 && (req_read || req_write) && !flush);
  endfunction

  function automatic logic [15:0] ref_load(logic [15:0] r, logic b, logic [15:0] a);
    if (!b) return r;
    if (a % 2 == 1) return r / 256;
    return r % 256;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = 0;
      m_load   = '0;
      m_stalls = 0;
      m_squash = 1'b0;
      chk_en   = 1;
    end else begin
      if (exp_stall()) m_stalls++;
      case (m_phase)
        0: if ((req_read || req_write) && !flush) begin
             m_rd = req_read; m_byte = req_byte;
             m_addr = req_addr; m_wdata = req_wdata;
             m_squash = 1'b0; m_phase = 1;
           end
        1: begin
             if (flush) m_squash = 1'b1;
             if (dmem_resp) begin
               if (m_rd) m_load = ref_load(dmem_rdata, m_byte, m_addr);
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        ew;
      logic [1:0]  ebe;
      ew  = (m_phase == 1) && !m_rd;
      ebe = !ew ? 2'b00 : (!m_byte ? 2'b11 : ((m_addr % 2 == 1) ? 2'b10 : 2'b01));
      check("stall", 32'(stall), 32'(exp_stall()));
      check("dmem_read", 32'(dmem_read), 32'((m_phase == 1) && m_rd));
      check("dmem_write", 32'(dmem_write), 32'(ew));
      check("dmem_address", 32'(dmem_address), (m_phase == 1) ? 32'(m_addr - (m_addr % 2)) : 32'd0);
      check("dmem_byte_enable", 32'(dmem_byte_enable), 32'(ebe));
      if (ew)
        check("dmem_wdata", 32'(dmem_wdata), m_byte ? 32'((m_wdata % 256) * 257) : 32'(m_wdata));
      else if (m_phase != 1)
        check("dmem_wdata_idle", 32'(dmem_wdata), 32'd0);
      check("load_valid", 32'(load_valid), 32'((m_phase == 2) && m_rd && !m_squash));
      check("load_data", 32'(load_data), 32'(m_load));
      check("stall_cycles", 32'(stall_cycles), (m_stalls > 15) ? 32'd15 : 32'(m_stalls));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_read = 0; req_write = 0; req_byte = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_req(); dmem_resp = 0;
    step(); step();
    rst = 0;
  endtask

  // Byte load with the response on the first ACCESS cycle.
  task automatic byte_load(input logic [15:0] a, input logic [15:0] r, input logic [15:0] exp);
    req_read = 1; req_byte = 1; req_addr = a;
    step();
    clear_req(); dmem_resp = 1; dmem_rdata = r;
    step();
    dmem_resp = 0;
    @(negedge clk);
    check("ldb_valid", 32'(load_valid), 32'd1);
    check("ldb_data", 32'(load_data), 32'(exp));
    step();
  endtask

  initial begin
    req_addr = '0; req_wdata = '0; dmem_rdata = '0;
    do_reset();

    // Word load, resp on second ACCESS cycle.
    req_read = 1; req_addr = 16'h3005;
    @(negedge clk);
    check("wl_stall_issue", 32'(stall), 32'd1);
    step();
    clear_req();
    @(negedge clk);
    check("wl_addr", 32'(dmem_address), 32'h3004);
    check("wl_read", 32'(dmem_read), 32'd1);
    step();
    dmem_resp = 1; dmem_rdata = 16'hBEEF;
    step();
    dmem_resp = 0;
    @(negedge clk);
    check("wl_valid", 32'(load_valid), 32'd1);
    check("wl_data", 32'(load_data), 32'hBEEF);
    check("wl_stall_done", 32'(stall), 32'd0);
    check("wl_count", 32'(stall_cycles), 32'd3);
    step();

    // Byte store to the high lane.
    req_write = 1; req_byte = 1; req_addr = 16'h1001; req_wdata = 16'h12AB;
    step();
    clear_req(); dmem_resp = 1;
    @(negedge clk);
    check("sb_wdata", 32'(dmem_wdata), 32'hABAB);
    check("sb_be", 32'(dmem_byte_enable), 32'h2);
    check("sb_addr", 32'(dmem_address), 32'h1000);
    check("sb_write", 32'(dmem_write), 32'd1);
    step();
    dmem_resp = 0;
    @(negedge clk);
    check("sb_no_valid", 32'(load_valid), 32'd0);
    step();

    byte_load(16'h2001, 16'h7F80, 16'h007F);
    byte_load(16'h2000, 16'h7F80, 16'h0080);

    // Flush during ACCESS.
    req_read = 1; req_byte = 0; req_addr = 16'h4000;
    step();
    clear_req(); flush = 1;
    @(negedge clk);
    check("fl_read_hold1", 32'(dmem_read), 32'd1);
    step();
    flush = 0;
    @(negedge clk);
    check("fl_read_hold2", 32'(dmem_read), 32'd1);
    dmem_resp = 1; dmem_rdata = 16'h5555;
    step();
    dmem_resp = 0;
    @(negedge clk);
    check("fl_no_valid", 32'(load_valid), 32'd0);
    check("fl_read_drop", 32'(dmem_read), 32'd0);
    step();

    // Reset mid-access followed by a stray response.
    req_read = 1; req_addr = 16'h6002;
    step();
    clear_req(); rst = 1;
    step();
    rst = 0; dmem_resp = 1; dmem_rdata = 16'hDEAD;
    @(negedge clk);
    check("rst_read", 32'(dmem_read), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_count", 32'(stall_cycles), 32'd0);
    check("rst_data", 32'(load_data), 32'd0);
    step();
    dmem_resp = 0;
    @(negedge clk);
    check("stray_valid", 32'(load_valid), 32'd0);
    check("stray_read", 32'(dmem_read), 32'd0);

    // Counter saturation at 4 bits.
    do_reset();
    req_read = 1; req_addr = 16'h0010;
    step();
    clear_req();
    repeat (20) step();
    @(negedge clk);
    check("sat_count", 32'(stall_cycles), 32'd15);
    check("sat_read", 32'(dmem_read), 32'd1);
    dmem_resp = 1;
    step();
    dmem_resp = 0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom % 300) == 0;
      req_read   = ($urandom % 4) == 0;
      req_write  = ($urandom % 4) == 0;
      req_byte   = $urandom % 2;
      req_addr   = 16'($urandom);
      req_wdata  = 16'($urandom);
      flush      = ($urandom % 10) == 0;
      dmem_resp  = ($urandom % 3) == 0;
      dmem_rdata = 16'($urandom);
      step();
    end
    rst = 0; clear_req(); dmem_resp = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
